instr_fetch_unit: RTL and testbench

Fetch sequencer between the program ROM and the instruction decoder. Owns the program counter and drives the ROM address, absorbing the ROM's 1-cycle synchronous read latency. Holds fetched bytes in a small prefetch FIFO tagged with their PC, and hands them to the decoder over a valid/ready handshake. Supports branch/jump redirect with flush, plus a halt request.

---
 rtl/instr_fetch_unit_pkg.sv | 13 +
 rtl/instr_fetch_unit_fetch_fifo.sv | 93 +++++++++
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e    : fetch sequencer state (running / halted)
//   IFU_RESET_VECTOR : default program counter value loaded on reset
package instr_fetch_unit_pkg;

    typedef enum logic [0:0] {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_e;

    localparam int IFU_RESET_VECTOR = 0;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch FIFO holding fetched entries ({byte, pc}) until the decoder takes them.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   push, push_data  : write an entry (dropped if full and not popping)
//   pop              : remove the head entry (ignored when empty)
//   flush            : discard all entries; wins over push and pop
//   count            : number of stored entries (0..DEPTH)
//   head             : head entry, forced to zero while empty
module fetch_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (pop && (count_r != {CNT_W{1'b0}})) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
        if (push && ((count_r != CNT_W'(DEPTH)) || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Pointer and occupancy registers; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (do_push_s && !do_pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (do_pop_s && !do_push_s) begin
                count_r <= count_r - CNT_W'(1);
            end
        end
    end

    // Entry storage; contents are don't-care while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Head is zeroed while empty so the decoder-facing outputs read 0 after reset/flush.
    always_comb begin
        head = {WIDTH{1'b0}};
        if (count_r != {CNT_W{1'b0}}) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = {WIDTH{1'b0}};
        end
    end

    assign count = count_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer between the program ROM and the instruction decoder.
// Owns the PC, absorbs the ROM's one-cycle read latency, buffers fetched bytes
// in a prefetch FIFO tagged with their PC, and supports redirect/flush and halt.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   rom_addr / rom_data        : ROM address out, registered ROM data in
//   instr_valid/data/pc/ready  : decoder handshake (pop on valid && ready)
//   redirect_valid/addr        : one-cycle flush and restart at redirect_addr
//   halt_req / halted          : stop issuing fetches / halted with nothing in flight
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 12,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    FIFO_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(IFU_RESET_VECTOR)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  halt_req,
    output logic                  halted
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;

    fetch_state_e          state_r;
    fetch_state_e          state_next_s;
    logic [ADDR_WIDTH-1:0] fetch_pc_r;
    logic [ADDR_WIDTH-1:0] inflight_pc_r;
    logic                  inflight_r;
    logic [CNT_W-1:0]      count_s;
    logic [ENTRY_W-1:0]    head_s;
    logic                  credit_ok_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  kill_s;
    logic                  issue_s;

    // Next-state logic: halt_req is a level, so the next state simply follows it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FS_RUN: begin
                if (halt_req) begin
                    state_next_s = FS_HALTED;
                end else begin
                    state_next_s = FS_RUN;
                end
            end
            FS_HALTED: begin
                if (!halt_req) begin
                    state_next_s = FS_RUN;
                end else begin
                    state_next_s = FS_HALTED;
                end
            end
            default: state_next_s = FS_RUN;
        endcase
    end

    // Fetch control. Credits count the in-flight byte so the FIFO can never overflow;
    // a same-cycle pop frees a slot. Issue is gated by the state being entered, so
    // halting stops issue at the sampling edge and un-halting resumes at that edge.
    // A redirect kills the byte returning at its edge and blocks issue for one cycle.
    always_comb begin
        pop_s       = 1'b0;
        kill_s      = 1'b0;
        push_s      = 1'b0;
        credit_ok_s = 1'b0;
        issue_s     = 1'b0;
        kill_s      = redirect_valid;
        pop_s       = instr_valid && instr_ready && !redirect_valid;
        push_s      = inflight_r && !kill_s;
        if (({1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r}) < (CNT_W + 1)'(FIFO_DEPTH)) begin
            credit_ok_s = 1'b1;
        end else begin
            credit_ok_s = 1'b0;
        end
        if ((state_next_s == FS_RUN) && !redirect_valid && (credit_ok_s || pop_s)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // State, PC and in-flight tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= FS_RUN;
            fetch_pc_r    <= RESET_VECTOR;
            inflight_pc_r <= {ADDR_WIDTH{1'b0}};
            inflight_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            inflight_r <= issue_s;
            if (redirect_valid) begin
                fetch_pc_r <= redirect_addr;
            end else if (issue_s) begin
                fetch_pc_r    <= fetch_pc_r + ADDR_WIDTH'(1);
                inflight_pc_r <= fetch_pc_r;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data ({rom_data, inflight_pc_r}),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .count     (count_s),
        .head      (head_s)
    );

    assign rom_addr    = fetch_pc_r;
    assign instr_valid = (count_s != {CNT_W{1'b0}});
    assign instr_data  = head_s[ENTRY_W-1:ADDR_WIDTH];
    assign instr_pc    = head_s[ADDR_WIDTH-1:0];
    assign halted      = (state_r == FS_HALTED) && !inflight_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a
// randomized phase; a negedge monitor checks every pop against an expected
// stream (sequential PCs since the last reset/redirect, data from the ROM array).
module tb_instr_fetch_unit;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = 8'h00;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = 12'h000;
    logic          halt_req = 1'b0;
    logic          halted;

    instr_fetch_unit #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (4),
        .RESET_VECTOR (12'h000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt_req       (halt_req),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // ROM with one-cycle registered read
    logic [DW-1:0] rom [0:4095];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int checks = 0;
    int errors = 0;

    // Reference model: after reset or redirect the decoder must see a contiguous
    // run of PCs (mod 4096) starting at the restart address, each with its ROM byte.
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] next_pc = 12'h000;
    int            rst_epoch = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_extend(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 12'd1;
        end
    endtask

    task automatic restart_stream(input logic [AW-1:0] start);
        exp_q.delete();
        next_pc = start;
        model_extend(8);
    endtask

    // Monitor: pops happen on edges where valid && ready && !redirect
    logic [AW-1:0] hold_pc;
    logic [DW-1:0] hold_data;
    logic          hold_v = 1'b0;
    int            hold_epoch = 0;
    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (hold_v && rst_n && (hold_epoch == rst_epoch)) begin
            chk("head_stable_pc", 32'(instr_pc), 32'(hold_pc));
            chk("head_stable_data", 32'(instr_data), 32'(hold_data));
        end
        hold_v = 1'b0;
        if (rst_n && instr_valid && !redirect_valid) begin
            if (instr_ready) begin
                if (exp_q.size() == 0) model_extend(8);
                e = exp_q.pop_front();
                chk("instr_pc", 32'(instr_pc), 32'(e));
                chk("instr_data", 32'(instr_data), 32'(rom[e]));
            end else begin
                hold_v     = 1'b1;
                hold_pc    = instr_pc;
                hold_data  = instr_data;
                hold_epoch = rst_epoch;
            end
        end
    end

    // Half-cycle reset pulse, immediate-zero check, then 2-edge restart latency
    task automatic do_reset(input logic rdy);
        @(posedge clk);
        #2;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = rdy;
        rst_n          = 1'b0;
        rst_epoch++;
        restart_stream(12'h000);
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_data", 32'(instr_data), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("lat_edge1_valid", 32'(instr_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_edge2_valid", 32'(instr_valid), 32'd1);
        chk("lat_edge2_pc", 32'(instr_pc), 32'd0);
    endtask

    // Called just after an edge: redirect is sampled at the next edge r
    task automatic do_redirect(input logic [AW-1:0] addr);
        redirect_valid = 1'b1;
        redirect_addr  = addr;
        restart_stream(addr);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        chk("redir_r_valid", 32'(instr_valid), 32'd0);
        @(posedge clk); #1;
        chk("redir_r1_valid", 32'(instr_valid), 32'd0);
        @(posedge clk); #1;
        chk("redir_r2_valid", 32'(instr_valid), 32'd1);
        chk("redir_r2_pc", 32'(instr_pc), 32'(addr));
    endtask

    initial begin
        logic [AW-1:0] saved_addr;
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[0] = 8'hA0; rom[1] = 8'hA1; rom[2] = 8'hA2; rom[3] = 8'hA3;
        rom[12'hFFE] = 8'h11; rom[12'hFFF] = 8'h22; rom[12'h000] = 8'hA0;

        // Reset release and sequential streaming
        do_reset(1'b1);
        chk("first_data", 32'(instr_data), 32'hA0);
        repeat (6) @(posedge clk);

        // Backpressure: FIFO fills, PC stops at 0 + depth
        do_reset(1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("bp_rom_addr", 32'(rom_addr), 32'd4);
        chk("bp_valid", 32'(instr_valid), 32'd1);
        chk("bp_head_pc", 32'(instr_pc), 32'd0);
        instr_ready = 1'b1;
        repeat (12) @(posedge clk);

        // Redirect while FIFO holds 3 and one fetch is in flight
        do_reset(1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_redir_rom_addr", 32'(rom_addr), 32'd4);
        instr_ready = 1'b1;
        do_redirect(12'h100);
        repeat (6) @(posedge clk);

        // PC wrap across 0xFFF
        #1;
        do_redirect(12'hFFE);
        chk("wrap_data", 32'(instr_data), 32'h11);
        repeat (6) @(posedge clk);

        // Halt mid-stream, drain, resume
        #1;
        halt_req = 1'b1;
        @(posedge clk); #1;
        chk("halt_halted", 32'(halted), 32'd1);
        saved_addr = rom_addr;
        repeat (6) @(posedge clk);
        #1;
        chk("halt_drained", 32'(instr_valid), 32'd0);
        chk("halt_pc_hold", 32'(rom_addr), 32'(saved_addr));
        chk("halt_still", 32'(halted), 32'd1);
        halt_req = 1'b0;
        @(posedge clk); #1;
        chk("unhalt_halted", 32'(halted), 32'd0);
        repeat (8) @(posedge clk);

        // Randomized phase: halted after every edge equals halt_req sampled at it
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            chk("rand_halted", 32'(halted), 32'(halt_req));
            redirect_valid = 1'b0;
            instr_ready    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) halt_req = ~halt_req;
            if ($urandom_range(0, 29) == 0) begin
                redirect_addr  = AW'($urandom);
                redirect_valid = 1'b1;
                restart_stream(redirect_addr);
            end
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        instr_ready    = 1'b1;
        repeat (10) @(posedge clk);

        // Reset pulse mid-stream
        do_reset(1'b1);
        repeat (10) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
